fc_layer_sequencer: RTL
=======================

Name: fc_layer_sequencer

Overview:
- Parametrised, runtime-programmable sequencer for a chain of up to MAX_LAYERS fully-connected layers.
- Replaces the fixed three-layer FC controller.
- Flow: loads flattened conv output from global SRAM into the FC buffer once, then runs each layer in turn on the FC compute core.
- Buffer read/write regions ping-pong automatically between layers.
- Layer descriptors are written through a config port before start; chain consistency is checked at start; abort and status are reported.

Parameters:
MAX_LAYERS, 4, descriptor table depth (1..8)
SRAM_ADDR_W, 16, global SRAM address width
LEN_W, 10, width of in_len/out_len fields
FB_ADDR_W, 10, FC buffer address width
PING_BASE, 0, FC buffer region A base
PONG_BASE, 512, FC buffer region B base
WDOG_CYCLES, 65535, watchdog limit (only with FC_WATCHDOG_EN)

Ports:
clk_i  in  1  clock
rst_async_n_i  in  1  async active-low reset
cfg_we_i  in  1  descriptor write strobe
cfg_idx_i  in  $clog2(MAX_LAYERS)  descriptor index
cfg_desc_i  in  fc_layer_desc_t  {in_len, out_len, do_bias, do_relu, do_quant, quant_shift[4:0]}
num_layers_i  in  $clog2(MAX_LAYERS+1)  layers to run; sampled on start
sram_base_i  in  SRAM_ADDR_W  source address of flattened input; sampled on start
start_i  in  1  start request
abort_i  in  1  abort request
load_done_i  in  1  FC buffer load complete (pulse)
core_done_i  in  1  layer compute complete (pulse)
busy_o  out  1  state != IDLE; drives global-buffer read mux
core_start_o  out  1  1-cycle pulse to FC core
load_from_sram_o  out  1  core operation is SRAM load
sram_load_addr_o  out  SRAM_ADDR_W  load source address
load_len_o  out  LEN_W  load length, or current layer in_len
calc_len_o  out  LEN_W  current layer out_len
do_bias_o / do_relu_o / do_quant_o  out  1 each  current layer flags
quant_shift_o  out  5  current layer shift
fb_rd_addr_o  out  FB_ADDR_W  FC buffer read base
fb_wr_addr_o  out  FB_ADDR_W  FC buffer write base
layer_idx_o  out  $clog2(MAX_LAYERS)  current layer
done_o  out  1  1-cycle completion pulse
err_o  out  1  config error; valid with done_o
aborted_o  out  1  run aborted; valid with done_o
timeout_o  out  1  watchdog fired; valid with done_o (0 if macro off)

Behaviour:
- Reset: all outputs 0, FSM IDLE, layer_idx 0, descriptor table cleared to 0.
- FSM states: IDLE, LOAD, LOAD_WAIT, RUN, WAIT, DONE.
- IDLE:
  - cfg_we_i writes table[cfg_idx_i]. Writes in any other state are ignored.
  - cfg_we_i and start_i in the same cycle: the write commits and the run uses the new value.
  - On start_i, sample num_layers_i and sram_base_i, then run the config check (combinational, same cycle). Check fails if num_layers==0, or num_layers>MAX_LAYERS, or table[k].in_len != table[k-1].out_len for any 1<=k<num_layers.
  - Check fail -> DONE with err_o=1; no core_start is ever issued.
  - Check pass -> LOAD.
- LOAD: one cycle. core_start_o=1, load_from_sram_o=1, sram_load_addr_o=base, load_len_o=table[0].in_len, fb_wr_addr_o=PING_BASE. Go to LOAD_WAIT.
- LOAD_WAIT: the same fields are held with core_start_o=0. On load_done_i go to RUN.
- RUN: one cycle, core_start_o=1.
  - Layer fields come from table[layer_idx].
  - Even idx: fb_rd=PING_BASE, fb_wr=PONG_BASE. Odd idx: reversed.
  - Go to WAIT.
- WAIT: fields held stable, core_start_o=0. On core_done_i:
  - if layer_idx==num_layers-1, go to DONE;
  - else layer_idx++ and go to RUN.
  - Layer-to-layer gap is exactly 1 cycle (WAIT->RUN).
- DONE: one cycle, done_o=1, status flags driven. Go to IDLE. layer_idx and status clear on IDLE entry.
- abort_i in LOAD..WAIT -> DONE with aborted_o=1. Abort has priority over a same-cycle load_done/core_done. abort_i in IDLE/DONE is ignored.
- start_i while busy is ignored.
- Stray load_done_i/core_done_i outside the waiting state are ignored.
- Config outputs are zero in IDLE and DONE.
- Reset mid-operation returns immediately to reset values and clears the table.

Optional Feature:
- FC_WATCHDOG_EN defined:
  - A counter of WDOG_CYCLES width clears on entry to LOAD_WAIT/WAIT and increments each cycle there.
  - On reaching WDOG_CYCLES -> DONE with timeout_o=1.
  - A done pulse on the limit cycle wins over the timeout.
- Undefined: no counter; timeout_o tied 0.

Decomposition:
- fc_pkg holds fc_layer_desc_t (packed struct), the state enum, and the default ping/pong bases.
- One sub-module, fc_desc_table: register file holding MAX_LAYERS descriptors, with write port, async read by layer_idx, and chain-check output.

Test Plan:
- 3-layer 400/120/84/10 table, num_layers=3, base 0x0800 -> LOAD pulse with addr 0x0800 len 400; then RUN pulses.
  - Layer 0: rd 0 / wr 512, len 400/120, relu 1.
  - Layer 1: rd 512 / wr 0, len 120/84.
  - Layer 2: rd 0 / wr 512, len 84/10, relu 0.
  - One done_o pulse, err=0.
- table[1].in_len=100 (mismatch), start -> done_o next cycle with err_o=1, zero core_start pulses.
- num_layers=0 and num_layers=5 (MAX=4) -> err_o=1.
- abort_i in the same cycle as core_done_i during layer 1 -> DONE with aborted_o=1, layer 2 never starts.
- cfg_we_i during WAIT -> table unchanged; the next run shows the original lengths.
- With FC_WATCHDOG_EN and WDOG_CYCLES=100, withhold core_done_i -> done_o with timeout_o=1 exactly 100 cycles after WAIT entry.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types for the FC layer sequencer: layer descriptor, FSM states and
// default ping/pong buffer bases.
package fc_pkg;

  localparam int FC_LEN_W         = 10;
  localparam int FC_PING_BASE_DEF = 0;
  localparam int FC_PONG_BASE_DEF = 512;

  typedef struct packed {
    logic [FC_LEN_W-1:0] in_len;
    logic [FC_LEN_W-1:0] out_len;
    logic                do_bias;
    logic                do_relu;
    logic                do_quant;
    logic [4:0]          quant_shift;
  } fc_layer_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_WAIT,
    S_RUN,
    S_WAIT,
    S_DONE
  } fc_state_e;

endpackage

// File: rtl/fc_desc_table.sv
// Descriptor register file with async read by layer index and a chain check
// that sees a same-cycle write, so a write issued alongside start is honoured.
module fc_desc_table
  import fc_pkg::*;
#(
  parameter int MAX_LAYERS = 4,
  parameter int IDX_W      = 2,
  parameter int NUM_W      = 3
) (
  input  logic           clk_i,
  input  logic           rst_async_n_i,
  input  logic           we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  fc_layer_desc_t wr_desc_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [NUM_W-1:0] num_layers_i,
  output fc_layer_desc_t rd_desc_o,
  output logic           chain_ok_o
);

  fc_layer_desc_t tbl_q [MAX_LAYERS];
  fc_layer_desc_t eff   [MAX_LAYERS];

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAYERS; i++)
        if (we_i && wr_idx_i == IDX_W'(i)) tbl_q[i] <= wr_desc_i;
    end
  end

  always_comb begin
    rd_desc_o = '0;
    for (int i = 0; i < MAX_LAYERS; i++)
      if (rd_idx_i == IDX_W'(i)) rd_desc_o = tbl_q[i];
  end

  always_comb begin
    for (int i = 0; i < MAX_LAYERS; i++)
      eff[i] = (we_i && wr_idx_i == IDX_W'(i)) ? wr_desc_i : tbl_q[i];
  end

  always_comb begin
    chain_ok_o = (num_layers_i != '0) && (int'(num_layers_i) <= MAX_LAYERS);
    for (int k = 1; k < MAX_LAYERS; k++)
      if (k < int'(num_layers_i) && eff[k].in_len != eff[k-1].out_len)
        chain_ok_o = 1'b0;
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Runtime-programmable FC layer chain sequencer (SRAM load, then per-layer runs
// with ping/pong buffer regions). Optional watchdog under FC_WATCHDOG_EN.
//
// state     | meaning
// IDLE      | accept descriptor writes, wait for start
// LOAD      | pulse core_start for the SRAM -> FC buffer load
// LOAD_WAIT | hold load fields until load_done
// RUN       | pulse core_start for layer layer_idx
// WAIT      | hold layer fields until core_done
// DONE      | one-cycle done pulse with status
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int MAX_LAYERS  = 4,
  parameter int SRAM_ADDR_W = 16,
  parameter int LEN_W       = 10,
  parameter int FB_ADDR_W   = 10,
  parameter int PING_BASE   = FC_PING_BASE_DEF,
  parameter int PONG_BASE   = FC_PONG_BASE_DEF,
  parameter int WDOG_CYCLES = 65535,
  localparam int IDX_W = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int NUM_W = $clog2(MAX_LAYERS + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_async_n_i,
  input  logic                   cfg_we_i,
  input  logic [IDX_W-1:0]       cfg_idx_i,
  input  fc_layer_desc_t         cfg_desc_i,
  input  logic [NUM_W-1:0]       num_layers_i,
  input  logic [SRAM_ADDR_W-1:0] sram_base_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   load_done_i,
  input  logic                   core_done_i,
  output logic                   busy_o,
  output logic                   core_start_o,
  output logic                   load_from_sram_o,
  output logic [SRAM_ADDR_W-1:0] sram_load_addr_o,
  output logic [LEN_W-1:0]       load_len_o,
  output logic [LEN_W-1:0]       calc_len_o,
  output logic                   do_bias_o,
  output logic                   do_relu_o,
  output logic                   do_quant_o,
  output logic [4:0]             quant_shift_o,
  output logic [FB_ADDR_W-1:0]   fb_rd_addr_o,
  output logic [FB_ADDR_W-1:0]   fb_wr_addr_o,
  output logic [IDX_W-1:0]       layer_idx_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   aborted_o,
  output logic                   timeout_o
);

  fc_state_e              state_q, state_d;
  logic [IDX_W-1:0]       layer_idx_q, layer_idx_d;
  logic [NUM_W-1:0]       num_q, num_d;
  logic [SRAM_ADDR_W-1:0] base_q, base_d;
  logic                   err_q, err_d, abort_q, abort_d, tmo_q, tmo_d;
  fc_layer_desc_t         cur_desc;
  logic                   chain_ok, last_layer, waiting, wdog_hit;

  fc_desc_table #(.MAX_LAYERS(MAX_LAYERS), .IDX_W(IDX_W), .NUM_W(NUM_W)) u_table (
    .clk_i        (clk_i),
    .rst_async_n_i(rst_async_n_i),
    .we_i         (cfg_we_i && state_q == S_IDLE),
    .wr_idx_i     (cfg_idx_i),
    .wr_desc_i    (cfg_desc_i),
    .rd_idx_i     (layer_idx_q),
    .num_layers_i (num_layers_i),
    .rd_desc_o    (cur_desc),
    .chain_ok_o   (chain_ok)
  );

  assign waiting    = (state_q == S_LOAD_WAIT) || (state_q == S_WAIT);
  assign last_layer = (NUM_W'(layer_idx_q) == num_q - NUM_W'(1));

`ifdef FC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  // Non-waiting states hold the counter at zero, so it starts fresh on each wait entry.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) wdog_q <= '0;
    else                wdog_q <= waiting ? wdog_q + WD_W'(1) : '0;
  end
  assign wdog_hit = waiting && (wdog_q == WD_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      state_q     <= S_IDLE;
      layer_idx_q <= '0;
      num_q       <= '0;
      base_q      <= '0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      num_q       <= num_d;
      base_q      <= base_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    num_d       = num_q;
    base_d      = base_q;
    err_d       = err_q;
    abort_d     = abort_q;
    tmo_d       = tmo_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        num_d  = num_layers_i;
        base_d = sram_base_i;
        if (chain_ok) state_d = S_LOAD;
        else begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_LOAD, S_RUN: begin
        if (abort_i) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end else state_d = (state_q == S_LOAD) ? S_LOAD_WAIT : S_WAIT;
      end
      // Abort outranks a same-cycle completion, and completion outranks the watchdog.
      S_LOAD_WAIT, S_WAIT: begin
        if (abort_i) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end else if (state_q == S_LOAD_WAIT && load_done_i) begin
          state_d = S_RUN;
        end else if (state_q == S_WAIT && core_done_i) begin
          if (last_layer) state_d = S_DONE;
          else begin
            state_d     = S_RUN;
            layer_idx_d = layer_idx_q + IDX_W'(1);
          end
        end else if (wdog_hit) begin
          state_d = S_DONE;
          tmo_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        layer_idx_d = '0;
        err_d       = 1'b0;
        abort_d     = 1'b0;
        tmo_d       = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_start_o     = (state_q == S_LOAD) || (state_q == S_RUN);
    load_from_sram_o = 1'b0;
    sram_load_addr_o = '0;
    load_len_o       = '0;
    calc_len_o       = '0;
    do_bias_o        = 1'b0;
    do_relu_o        = 1'b0;
    do_quant_o       = 1'b0;
    quant_shift_o    = '0;
    fb_rd_addr_o     = '0;
    fb_wr_addr_o     = '0;
    if (state_q == S_LOAD || state_q == S_LOAD_WAIT) begin
      load_from_sram_o = 1'b1;
      sram_load_addr_o = base_q;
      load_len_o       = LEN_W'(cur_desc.in_len);
      fb_wr_addr_o     = FB_ADDR_W'(PING_BASE);
    end else if (state_q == S_RUN || state_q == S_WAIT) begin
      load_len_o    = LEN_W'(cur_desc.in_len);
      calc_len_o    = LEN_W'(cur_desc.out_len);
      do_bias_o     = cur_desc.do_bias;
      do_relu_o     = cur_desc.do_relu;
      do_quant_o    = cur_desc.do_quant;
      quant_shift_o = cur_desc.quant_shift;
      fb_rd_addr_o  = layer_idx_q[0] ? FB_ADDR_W'(PONG_BASE) : FB_ADDR_W'(PING_BASE);
      fb_wr_addr_o  = layer_idx_q[0] ? FB_ADDR_W'(PING_BASE) : FB_ADDR_W'(PONG_BASE);
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign layer_idx_o = layer_idx_q;
  assign done_o      = (state_q == S_DONE);
  assign err_o       = done_o & err_q;
  assign aborted_o   = done_o & abort_q;
  assign timeout_o   = done_o & tmo_q;

endmodule
